mod_n_stream: RTL and testbench

- Parametrised serial residue engine: computes (bit-stream value) mod N, MSB-first, consuming BITS bits per accepted beat.
- Modulus N is runtime-selectable per frame; frames are delimited by start/last markers.
- The final residue is presented on a valid/ready result port with a divisibility flag and an error flag.
- Sits between stream producers (bit deserialisers, checksum front-ends) and control logic that needs divisibility or residue tests.

---
 rtl/mod_n_stream.sv | 109 ++++++++++
 tb/tb_mod_n_stream.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_stream.sv
// rtl/mod_n_stream.sv - serial MSB-first residue engine computing (stream value) mod N
// Consumes BITS bits per accepted beat; result is held on a valid/ready port.
module mod_n_stream #(
  parameter int MOD_W = 8,
  parameter int BITS  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             start_i,
  input  logic             last_i,
  input  logic [BITS-1:0]  data_i,
  input  logic [MOD_W-1:0] mod_n_i,
  output logic [MOD_W-1:0] res_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             divisible_o,
  output logic             res_err_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [MOD_W-1:0] res_q, res_d;
  logic [MOD_W-1:0] n_q, n_d;
  logic             err_q, err_d;

  logic [MOD_W-1:0] step_n;
  logic [MOD_W-1:0] step_r;
  logic [MOD_W:0]   step_t;

  // A start beat restarts the chain from zero with the freshly offered modulus.
  always_comb begin
    step_n = start_i ? mod_n_i : n_q;
    step_r = start_i ? '0 : res_q;
    step_t = '0;
    for (int i = BITS - 1; i >= 0; i--) begin
      step_t = {step_r, data_i[i]};
      if (step_t >= {1'b0, step_n}) begin
        step_t = step_t - {1'b0, step_n};
      end
      step_r = step_t[MOD_W-1:0];
    end
    if (step_n == '0) begin
      step_r = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    n_d     = n_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (valid_i && start_i) begin
          n_d     = mod_n_i;
          res_d   = step_r;
          err_d   = (mod_n_i == '0);
          state_d = last_i ? HOLD : ACC;
        end
      end
      ACC: begin
        if (valid_i) begin
          res_d = step_r;
          if (start_i) begin
            // Restart: abandoned frame taints the next result.
            n_d   = mod_n_i;
            err_d = 1'b1;
          end
          if (last_i) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (res_ready_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  assign ready_o     = reset && (state_q != HOLD);
  assign res_valid_o = reset && (state_q == HOLD);
  assign busy_o      = reset && (state_q != IDLE);
  assign res_o       = reset ? res_q : '0;
  assign divisible_o = res_valid_o && (res_q == '0) && !err_q;
  assign res_err_o   = res_valid_o && err_q;

endmodule

// File: tb/tb_mod_n_stream.sv
// tb/tb_mod_n_stream.sv - randomized and directed bench for mod_n_stream
// Arithmetic reference model checked every cycle, plus hand-computed literals.
module tb_mod_n_stream;

  localparam int MOD_W = 8;
  localparam int BITS  = 2;

  logic             clk;
  logic             reset;
  logic             valid_i;
  logic             ready_o;
  logic             start_i;
  logic             last_i;
  logic [BITS-1:0]  data_i;
  logic [MOD_W-1:0] mod_n_i;
  logic [MOD_W-1:0] res_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic             divisible_o;
  logic             res_err_o;
  logic             busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  mod_n_stream #(.MOD_W(MOD_W), .BITS(BITS)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .start_i(start_i), .last_i(last_i), .data_i(data_i), .mod_n_i(mod_n_i),
    .res_o(res_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .divisible_o(divisible_o), .res_err_o(res_err_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: frame phase, latched modulus, and residue as plain integer arithmetic.
  int m_phase = 0;  // 0 idle, 1 in frame, 2 result pending
  int m_res   = 0;
  int m_n     = 0;
  bit m_err   = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = 0; m_res = 0; m_n = 0; m_err = 1'b0;
    end else if (m_phase == 2) begin
      if (res_ready_i) begin
        m_phase = 0; m_err = 1'b0;
      end
    end else if (valid_i && (start_i || m_phase == 1)) begin
      if (start_i) begin
        m_err = (mod_n_i == 0) || (m_phase == 1);
        m_n   = mod_n_i;
        m_res = 0;
      end
      m_res   = (m_n == 0) ? 0 : (m_res * (1 << BITS) + int'(data_i)) % m_n;
      m_phase = last_i ? 2 : 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit hv;
    hv = reset && (m_phase == 2);
    chk("ready_o", int'(ready_o), int'(reset && m_phase != 2));
    chk("res_valid_o", int'(res_valid_o), int'(hv));
    chk("busy_o", int'(busy_o), int'(reset && m_phase != 0));
    chk("res_o", int'(res_o), reset ? m_res : 0);
    chk("divisible_o", int'(divisible_o), int'(hv && m_res == 0 && !m_err));
    chk("res_err_o", int'(res_err_o), int'(hv && m_err));
  end

  task automatic idle_inputs();
    valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0;
    data_i = '0; mod_n_i = '0; res_ready_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit s, input bit l, input int d, input int n);
    valid_i = 1'b1; start_i = s; last_i = l;
    data_i = d[BITS-1:0]; mod_n_i = n[MOD_W-1:0];
    tick();
    valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic consume();
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    chk("lit reset res_o", int'(res_o), 0);
    chk("lit reset busy", int'(busy_o), 0);
    reset = 1'b1;
    tick();

    // 13 mod 5
    beat(1, 0, 2'b11, 5);
    chk("lit n5 beat1 res", int'(res_o), 3);
    beat(0, 1, 2'b01, 0);
    chk("lit n5 valid", int'(res_valid_o), 1);
    chk("lit n5 res", int'(res_o), 3);
    chk("lit n5 div", int'(divisible_o), 0);
    chk("lit n5 err", int'(res_err_o), 0);
    consume();

    // 255 mod 7 with a stalled consumer and an offered beat
    beat(1, 0, 2'b11, 7);
    beat(0, 0, 2'b11, 0);
    beat(0, 0, 2'b11, 0);
    beat(0, 1, 2'b11, 0);
    for (int i = 0; i < 3; i++) begin
      chk("lit n7 ready", int'(ready_o), 0);
      chk("lit n7 res", int'(res_o), 3);
      beat(1, 1, 2'b10, 9);
    end
    consume();
    chk("lit n7 idle", int'(busy_o), 0);
    chk("lit n7 hold res", int'(res_o), 3);

    // 57 mod 3, then N=1
    beat(1, 0, 2'b11, 3);
    beat(0, 0, 2'b10, 0);
    beat(0, 1, 2'b01, 0);
    chk("lit n3 res", int'(res_o), 0);
    chk("lit n3 div", int'(divisible_o), 1);
    consume();
    beat(1, 0, 2'b10, 1);
    beat(0, 1, 2'b11, 0);
    chk("lit n1 div", int'(divisible_o), 1);
    consume();

    // Restart: 11 mod 6 with error
    beat(1, 0, 2'b11, 5);
    beat(1, 0, 2'b10, 6);
    beat(0, 1, 2'b11, 0);
    chk("lit restart res", int'(res_o), 5);
    chk("lit restart err", int'(res_err_o), 1);
    consume();

    // N=0 single beat, then a stray beat in IDLE
    beat(1, 1, 2'b11, 0);
    chk("lit n0 valid", int'(res_valid_o), 1);
    chk("lit n0 res", int'(res_o), 0);
    chk("lit n0 err", int'(res_err_o), 1);
    chk("lit n0 div", int'(divisible_o), 0);
    consume();
    beat(0, 1, 2'b11, 4);
    chk("lit stray busy", int'(busy_o), 0);

    // Reset mid-frame
    beat(1, 0, 2'b11, 7);
    beat(0, 0, 2'b01, 0);
    reset = 1'b0;
    #2;
    chk("lit rst res_o", int'(res_o), 0);
    chk("lit rst valid", int'(res_valid_o), 0);
    chk("lit rst busy", int'(busy_o), 0);
    tick();
    reset = 1'b1;
    beat(1, 0, 2'b10, 5);
    beat(0, 1, 2'b10, 0);
    chk("lit n5b res", int'(res_o), 0);
    consume();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int sel;
      valid_i     = ($urandom_range(0, 3) != 0);
      start_i     = ($urandom_range(0, 5) == 0);
      last_i      = ($urandom_range(0, 4) == 0);
      data_i      = BITS'($urandom);
      sel         = $urandom_range(0, 9);
      mod_n_i     = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : MOD_W'($urandom_range(2, 255));
      res_ready_i = ($urandom_range(0, 2) == 0);
      reset       = ($urandom_range(0, 199) != 0);
      tick();
    end
    idle_inputs();
    reset = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
